mem_slave_ws: RTL and testbench
===============================

# mem_slave_ws

Parametrised memory slave that answers the bench's valid/ready memory bus, replacing the fixed-width macro-sized target. It adds byte-lane write strobes, a configurable number of wait states, and an error response for out-of-range addresses. It sits behind the bus interface as the DUT the memory testbench drives and monitors.

## Interface
- WIDTH, 32: data width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8: word-address width.
- DEPTH, 2**ADDR_WIDTH: number of implemented words; must be ≤ 2**ADDR_WIDTH.
- WAIT_STATES, 0: extra cycles between accept and ready; range 0..15.
- clk  in  1  clock; all logic on posedge.
- rst  in  1  one clock; reset is asynchronous and active-low.
- valid  in  1  request present; master holds it and all request fields stable until ready.
- wr_rd  in  1  1 = write, 0 = read.
- addr  in  ADDR_WIDTH  word address.
- wdata  in  WIDTH  write data.
- wstrb  in  WIDTH/8  byte enables for writes; ignored on reads.
- ready  out  1  one-cycle completion pulse.
- rdata  out  WIDTH  read data; valid in the ready cycle and held until the next read completes.
- err  out  1  qualified by ready; 1 = address ≥ DEPTH.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: on valid=1, latch wr_rd/addr/wdata/wstrb and load wait_cnt = WAIT_STATES.
  - WAIT_STATES = 0: go to RESP.
  - Otherwise: go to WAIT.
- WAIT: decrement wait_cnt; go to RESP when wait_cnt reaches 1.
- RESP: ready=1 for exactly one cycle, then go to IDLE unconditionally.
- Write commit: on the edge entering RESP, store each byte lane i with wstrb[i]=1. Lanes with wstrb[i]=0 keep their old value.
- wstrb = 0: legal. Completes with ready, nothing is written, err=0.
- Read: rdata is loaded from the array on the edge entering RESP.
- Writes do not change rdata.
- Out of range (addr ≥ DEPTH):
  - Writes are dropped.
  - Reads load rdata = 0.
  - err=1 in the RESP cycle.
- err is 0 whenever ready=0.
- Changes to valid or request fields after accept are ignored; the latched request completes.
- valid still high in the RESP cycle belongs to the completing transaction and is not re-accepted.
- Array contents are not reset. Reads of unwritten words return X in simulation.

## Timing
- Reset values: ready=0, err=0, rdata=0, state=IDLE, wait_cnt=0.
- Reset assertion mid-transaction aborts the transaction.
  - If rst falls before the commit edge, the write is not committed.
  - The FSM returns to IDLE asynchronously.
- Accept in cycle T (valid sampled high in IDLE) → ready high in cycle T+1+WAIT_STATES.
- Minimum spacing: 2+WAIT_STATES cycles per transaction. The next accept is earliest in cycle T+2+WAIT_STATES.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package mem_pkg:
  - default WIDTH and ADDR_WIDTH localparams, replacing the global defines;
  - state_e enum (IDLE, WAIT, RESP);
  - a req_t struct {wr_rd, addr, wdata, wstrb} for the latched request.
- Sub-module mem_array: DEPTH×WIDTH storage with a byte-enabled synchronous write port and a synchronous read port, no reset. The FSM and response logic stay in mem_slave_ws.
- The existing interface gains wstrb and err, and both clocking blocks add them.

## Test plan
- Reset then idle: hold rst low 3 cycles, release, valid=0 for 5 cycles → ready=0, err=0, rdata=0 throughout.
- WAIT_STATES=0: write addr 0x05 = 0xDEADBEEF with wstrb=0xF at T → ready at T+1. Then read 0x05 → ready 1 cycle after accept, rdata=0xDEADBEEF, err=0.
- Byte strobes: write 0x10 = 0x11223344 (wstrb=0xF), then 0x10 = 0xAABBCCDD (wstrb=0x5). Read 0x10 → 0x11BB33DD.
- WAIT_STATES=3 back-to-back: valid held high across two reads → each ready exactly 4 cycles after its accept, accepts 5 cycles apart, one ready pulse per transaction.
- Out of range with DEPTH=200: write 0xF0 = 0x1 → ready with err=1. Read 0xF0 → rdata=0, err=1. Read an in-range word → err=0 and its data unchanged.
- Reset mid-write: WAIT_STATES=3, write 0x20 = 0xCAFEF00D over a known old value 0x12345678. Assert rst 2 cycles after accept → no ready. After release, read 0x20 → 0x12345678.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_pkg : shared defaults, FSM encoding and helpers for mem_slave_ws
// Rev 1.0
// ---------------------------------------------------------------------------
package mem_pkg;

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_ADDR_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // DEPTH may be smaller than the address space, so range is checked numerically
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        return (addr < depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_slave_ws_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_slave_ws_if : valid/ready memory bus with byte strobes and error flag
// Rev 1.0
// ---------------------------------------------------------------------------
interface mem_slave_ws_if
    import mem_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

    logic                    valid;
    logic                    wr_rd;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [WIDTH-1:0]        wdata;
    logic [WIDTH/8-1:0]      wstrb;
    logic                    ready;
    logic [WIDTH-1:0]        rdata;
    logic                    err;

    modport master (
        output valid, wr_rd, addr, wdata, wstrb,
        input  ready, rdata, err
    );

    modport slave (
        input  valid, wr_rd, addr, wdata, wstrb,
        output ready, rdata, err
    );

endinterface
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_array : DEPTH x WIDTH storage, byte-enabled sync write, sync read, no reset
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_array #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 2**ADDR_WIDTH
) (
    input  wire logic                  clk,
    input  wire logic                  we,
    input  wire logic                  re,
    input  wire logic [ADDR_WIDTH-1:0] addr,
    input  wire logic [WIDTH-1:0]      wdata,
    input  wire logic [WIDTH/8-1:0]    wstrb,
    output logic      [WIDTH-1:0]      rdata
);

    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (wstrb[i]) begin
                    mem_q[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
        if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/mem_slave_ws.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_slave_ws : memory slave with write strobes, wait states and range error
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_slave_ws
    import mem_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DEPTH       = 2**ADDR_WIDTH,
    parameter int WAIT_STATES = 0
) (
    input wire logic      clk,
    input wire logic      rst,
    mem_slave_ws_if.slave bus
);

    localparam int         NB     = WIDTH / 8;
    localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

    typedef struct packed {
        logic                  wr_rd;
        logic [ADDR_WIDTH-1:0] addr;
        logic [WIDTH-1:0]      wdata;
        logic [NB-1:0]         wstrb;
    } req_t;

    state_e           state_q, state_d;
    logic [3:0]       wait_cnt_q, wait_cnt_d;
    req_t             req_q, req_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;
    logic             rsel_q, rsel_d;
    logic             commit;
    logic             in_range;
    logic             mem_we, mem_re;
    logic [WIDTH-1:0] mem_rdata;

    // req_d is the request being committed on the edge entering RESP,
    // whether it comes straight from the bus (no wait states) or from req_q.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        req_d      = req_q;
        commit     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.valid) begin
                    req_d.wr_rd = bus.wr_rd;
                    req_d.addr  = bus.addr;
                    req_d.wdata = bus.wdata;
                    req_d.wstrb = bus.wstrb;
                    wait_cnt_d  = WS_CNT;
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                wait_cnt_d = wait_cnt_q - 4'd1;
                if (wait_cnt_q == 4'd1) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_range = addr_in_range(32'(req_d.addr), DEPTH);
        mem_we   = commit &  req_d.wr_rd & in_range;
        mem_re   = commit & ~req_d.wr_rd & in_range;
        ready_d  = commit;
        err_d    = commit & ~in_range;
        rsel_d   = rsel_q;
        // rsel selects array data vs. zero; only reads move it
        if (commit && !req_d.wr_rd) begin
            rsel_d = in_range;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= 4'd0;
            req_q      <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            rsel_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            req_q      <= req_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            rsel_q     <= rsel_d;
        end
    end

    mem_array #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem_array (
        .clk   (clk),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (req_d.addr),
        .wdata (req_d.wdata),
        .wstrb (req_d.wstrb),
        .rdata (mem_rdata)
    );

    assign bus.ready = ready_q;
    assign bus.err   = err_q;
    assign bus.rdata = rsel_q ? mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_slave_ws.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_slave_ws : directed self-checking bench for mem_slave_ws
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mem_slave_ws;

    logic clk = 1'b0;
    logic rst0;
    logic rst3;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_slave_ws_if #(.WIDTH(32), .ADDR_WIDTH(8)) if0 ();
    mem_slave_ws_if #(.WIDTH(32), .ADDR_WIDTH(8)) if3 ();

    mem_slave_ws #(.WIDTH(32), .ADDR_WIDTH(8), .DEPTH(256), .WAIT_STATES(0)) dut0 (
        .clk (clk),
        .rst (rst0),
        .bus (if0)
    );

    mem_slave_ws #(.WIDTH(32), .ADDR_WIDTH(8), .DEPTH(200), .WAIT_STATES(3)) dut3 (
        .clk (clk),
        .rst (rst3),
        .bus (if3)
    );

    task automatic drive(input int d, input logic v, input logic wr, input logic [7:0] a,
                         input logic [31:0] wd, input logic [3:0] st);
        if (d == 0) begin
            if0.valid = v; if0.wr_rd = wr; if0.addr = a; if0.wdata = wd; if0.wstrb = st;
        end else begin
            if3.valid = v; if3.wr_rd = wr; if3.addr = a; if3.wdata = wd; if3.wstrb = st;
        end
    endtask

    task automatic sample(input int d, output logic r, output logic [31:0] rd, output logic e);
        if (d == 0) begin
            r = if0.ready; rd = if0.rdata; e = if0.err;
        end else begin
            r = if3.ready; rd = if3.rdata; e = if3.err;
        end
    endtask

    // lat = number of falling edges from drive to the ready pulse, -1 on timeout
    task automatic txn(input int d, input logic wr, input logic [7:0] a, input logic [31:0] wd,
                       input logic [3:0] st, output int lat, output logic [31:0] rd,
                       output logic e, output logic rdy_after);
        logic        r;
        logic [31:0] dd;
        logic        ee;
        drive(d, 1'b1, wr, a, wd, st);
        lat = -1; rd = '0; e = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            sample(d, r, dd, ee);
            if (r === 1'b1) begin
                lat = k; rd = dd; e = ee;
                break;
            end
        end
        drive(d, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        @(negedge clk);
        sample(d, rdy_after, dd, ee);
    endtask

    task automatic test_reset;
        logic        r;
        logic [31:0] rd;
        logic        e;
        rst0 = 1'b0; rst3 = 1'b0;
        drive(0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        drive(3, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        repeat (3) @(negedge clk);
        rst0 = 1'b1; rst3 = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            for (int d = 0; d <= 3; d += 3) begin
                sample(d, r, rd, e);
                checks++;
                if (r !== 1'b0 || e !== 1'b0 || rd !== 32'h0) begin
                    errors++;
                    $display("FAIL reset_idle dut%0d cyc%0d: got ready=%b err=%b rdata=%h expected 0/0/00000000",
                             d, c, r, e, rd);
                end
            end
        end
    endtask

    task automatic test_ws0;
        int lat; logic [31:0] rd; logic e; logic ra;
        txn(0, 1'b1, 8'h05, 32'hDEADBEEF, 4'hF, lat, rd, e, ra);
        checks++;
        if (lat !== 1 || e !== 1'b0 || ra !== 1'b0) begin
            errors++;
            $display("FAIL ws0_write: got lat=%0d err=%b ready_after=%b expected 1/0/0", lat, e, ra);
        end
        txn(0, 1'b0, 8'h05, 32'h0, 4'h0, lat, rd, e, ra);
        checks++;
        if (lat !== 1 || rd !== 32'hDEADBEEF || e !== 1'b0 || ra !== 1'b0) begin
            errors++;
            $display("FAIL ws0_read: got lat=%0d rdata=%h err=%b ready_after=%b expected 1/deadbeef/0/0",
                     lat, rd, e, ra);
        end
        txn(0, 1'b1, 8'h06, 32'h00000000, 4'hF, lat, rd, e, ra);
        checks++;
        if (lat !== 1 || rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_keeps_rdata: got lat=%0d rdata=%h expected 1/deadbeef", lat, rd);
        end
    endtask

    task automatic test_strobes;
        int lat; logic [31:0] rd; logic e; logic ra;
        txn(0, 1'b1, 8'h10, 32'h11223344, 4'hF, lat, rd, e, ra);
        txn(0, 1'b1, 8'h10, 32'hAABBCCDD, 4'h5, lat, rd, e, ra);
        txn(0, 1'b0, 8'h10, 32'h0, 4'h0, lat, rd, e, ra);
        checks++;
        if (rd !== 32'h11BB33DD || e !== 1'b0) begin
            errors++;
            $display("FAIL strobe_merge: got rdata=%h err=%b expected 11bb33dd/0", rd, e);
        end
        txn(0, 1'b1, 8'h10, 32'hFFFFFFFF, 4'h0, lat, rd, e, ra);
        checks++;
        if (lat !== 1 || e !== 1'b0) begin
            errors++;
            $display("FAIL zero_strobe_write: got lat=%0d err=%b expected 1/0", lat, e);
        end
        txn(0, 1'b0, 8'h10, 32'h0, 4'h0, lat, rd, e, ra);
        checks++;
        if (rd !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL zero_strobe_keep: got rdata=%h expected 11bb33dd", rd);
        end
    endtask

    task automatic test_back_to_back;
        int lat; logic [31:0] rd; logic e; logic ra; logic r; logic exp_r;
        txn(3, 1'b1, 8'h01, 32'h000000A1, 4'hF, lat, rd, e, ra);
        checks++;
        if (lat !== 4 || e !== 1'b0 || ra !== 1'b0) begin
            errors++;
            $display("FAIL ws3_write_latency: got lat=%0d err=%b ready_after=%b expected 4/0/0", lat, e, ra);
        end
        txn(3, 1'b1, 8'h02, 32'h000000B2, 4'hF, lat, rd, e, ra);
        drive(3, 1'b1, 1'b0, 8'h01, 32'h0, 4'h0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            sample(3, r, rd, e);
            exp_r = (k == 4) || (k == 9);
            checks++;
            if (r !== exp_r) begin
                errors++;
                $display("FAIL b2b_ready k=%0d: got ready=%b expected %b", k, r, exp_r);
            end
            if (k == 4) begin
                checks++;
                if (rd !== 32'h000000A1 || e !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_rdata1: got rdata=%h err=%b expected 000000a1/0", rd, e);
                end
                drive(3, 1'b1, 1'b0, 8'h02, 32'h0, 4'h0);
            end
            if (k == 9) begin
                checks++;
                if (rd !== 32'h000000B2 || e !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_rdata2: got rdata=%h err=%b expected 000000b2/0", rd, e);
                end
                drive(3, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
            end
        end
    endtask

    task automatic test_out_of_range;
        int lat; logic [31:0] rd; logic e; logic ra;
        txn(3, 1'b1, 8'hF0, 32'h00000001, 4'hF, lat, rd, e, ra);
        checks++;
        if (lat !== 4 || e !== 1'b1 || ra !== 1'b0) begin
            errors++;
            $display("FAIL oor_write: got lat=%0d err=%b ready_after=%b expected 4/1/0", lat, e, ra);
        end
        txn(3, 1'b0, 8'hF0, 32'h0, 4'h0, lat, rd, e, ra);
        checks++;
        if (rd !== 32'h0 || e !== 1'b1) begin
            errors++;
            $display("FAIL oor_read: got rdata=%h err=%b expected 00000000/1", rd, e);
        end
        txn(3, 1'b0, 8'h01, 32'h0, 4'h0, lat, rd, e, ra);
        checks++;
        if (rd !== 32'h000000A1 || e !== 1'b0) begin
            errors++;
            $display("FAIL in_range_after_oor: got rdata=%h err=%b expected 000000a1/0", rd, e);
        end
        txn(3, 1'b1, 8'hC7, 32'h5A5A5A5A, 4'hF, lat, rd, e, ra);
        checks++;
        if (e !== 1'b0) begin
            errors++;
            $display("FAIL last_word_write: got err=%b expected 0", e);
        end
        txn(3, 1'b0, 8'hC7, 32'h0, 4'h0, lat, rd, e, ra);
        checks++;
        if (rd !== 32'h5A5A5A5A || e !== 1'b0) begin
            errors++;
            $display("FAIL last_word_read: got rdata=%h err=%b expected 5a5a5a5a/0", rd, e);
        end
        txn(3, 1'b0, 8'hC8, 32'h0, 4'h0, lat, rd, e, ra);
        checks++;
        if (rd !== 32'h0 || e !== 1'b1) begin
            errors++;
            $display("FAIL first_oor_read: got rdata=%h err=%b expected 00000000/1", rd, e);
        end
    endtask

    task automatic test_reset_mid_write;
        int lat; logic [31:0] rd; logic e; logic ra; logic r;
        txn(3, 1'b1, 8'h20, 32'h12345678, 4'hF, lat, rd, e, ra);
        drive(3, 1'b1, 1'b1, 8'h20, 32'hCAFEF00D, 4'hF);
        repeat (2) @(negedge clk);
        rst3 = 1'b0;
        drive(3, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            sample(3, r, rd, e);
            checks++;
            if (r !== 1'b0 || e !== 1'b0 || rd !== 32'h0) begin
                errors++;
                $display("FAIL mid_reset_outputs cyc%0d: got ready=%b err=%b rdata=%h expected 0/0/00000000",
                         c, r, e, rd);
            end
        end
        rst3 = 1'b1;
        @(negedge clk);
        txn(3, 1'b0, 8'h20, 32'h0, 4'h0, lat, rd, e, ra);
        checks++;
        if (lat !== 4 || rd !== 32'h12345678 || e !== 1'b0) begin
            errors++;
            $display("FAIL aborted_write: got lat=%0d rdata=%h err=%b expected 4/12345678/0", lat, rd, e);
        end
    endtask

    initial begin
        test_reset();
        test_ws0();
        test_strobes();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no completion expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
